// File: rtl/tff_updown_counter_pkg.sv
// Shared constants and helpers for the T-flip-flop counter family.
//   DIR_UP / DIR_DOWN   : encoding of the direction input
//   clog2()             : ceiling log2, for sizing counters from a modulus
//   DEC_* / HEX_*       : default width/modulus for decade and hex stages
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int DEC_WIDTH   = 4;
   localparam int DEC_MODULUS = 10;
   localparam int HEX_WIDTH   = 4;
   localparam int HEX_MODULUS = 16;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tff_updown_counter_cell.sv
// Single T flip-flop cell.
//   CLK  : rising-edge clock
//   RST  : asynchronous active-high reset, clears Q
//   T    : toggle enable
//   Q    : stored bit
//   Qbar : complement of Q
module tff_cell (
   input  logic CLK,
   input  logic RST,
   input  logic T,
   output logic Q,
   output logic Qbar
);

   logic q_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)    q_q <= 1'b0;
      else if (T) q_q <= ~q_q;
   end

   assign Q    = q_q;
   assign Qbar = ~q_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Up/down modulo counter built from WIDTH T flip-flop cells. The next count
// is computed as a plain value and each cell is toggled where it differs from
// the current count, so load, wrap and out-of-range recovery all share one
// toggle path. For a full binary modulus this reduces to the classic
// ripple-AND toggle terms.
//   CLK, RST   : clock, asynchronous active-high reset
//   EN, UP     : count enable, direction (1 = up)
//   LOAD, D    : synchronous parallel load (rejected when D >= MODULUS)
//   Q, Qbar    : count value and its complement
//   TC         : combinational carry/borrow enable for the next stage
//   WRAP       : one-cycle pulse after a wrap edge
//   LOAD_ERR   : one-cycle pulse after a rejected load
module tff_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH   = HEX_WIDTH,
   parameter int MODULUS = HEX_MODULUS
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             TC,
   output logic             WRAP,
   output logic             LOAD_ERR
);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH) || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
      $error("tff_updown_counter: MODULUS out of range for WIDTH");
   end

   // One extra bit so a modulus of exactly 2^WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] t;
   logic             in_range, d_ok, at_max, at_min;
   logic             wrap_d, wrap_q;
   logic             load_err_d, load_err_q;

   assign in_range = {1'b0, Q} < MOD_EXT;
   assign d_ok     = {1'b0, D} < MOD_EXT;
   assign at_max   = (Q == Q_MAX);
   assign at_min   = (Q == '0);

   always_comb begin
      q_d        = Q;
      wrap_d     = 1'b0;
      load_err_d = 1'b0;
      if (LOAD) begin
         if (d_ok) q_d        = D;
         else      load_err_d = 1'b1;
      end else if (EN) begin
         if (!in_range) begin
            // Unreachable in normal operation; recover rather than lock up.
            q_d = '0;
         end else if (UP == DIR_UP) begin
            if (at_max) begin
               q_d    = '0;
               wrap_d = 1'b1;
            end else begin
               q_d = Q + ONE;
            end
         end else begin
            if (at_min) begin
               q_d    = Q_MAX;
               wrap_d = 1'b1;
            end else begin
               q_d = Q - ONE;
            end
         end
      end
   end

   assign t = Q ^ q_d;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
         .CLK  (CLK),
         .RST  (RST),
         .T    (t[i]),
         .Q    (Q[i]),
         .Qbar (Qbar[i])
      );
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         wrap_q     <= wrap_d;
         load_err_q <= load_err_d;
      end
   end

   assign TC       = EN & ~LOAD & ((UP == DIR_UP) ? at_max : at_min);
   assign WRAP     = wrap_q;
   assign LOAD_ERR = load_err_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
module tb_tff_updown_counter;

   logic clk = 1'b0;
   logic rst;

   // hex instance (4/16)
   logic       h_en, h_up, h_load;
   logic [3:0] h_d, h_q, h_qb;
   logic       h_tc, h_wrap, h_lerr;
   // decade instance (4/10)
   logic       d_en, d_up, d_load;
   logic [3:0] d_d, d_q, d_qb;
   logic       d_tc, d_wrap, d_lerr;
   // cascade: units and tens (4/10)
   logic       u_en;
   logic [3:0] u_q, u_qb, t_q, t_qb;
   logic       u_tc, u_wrap, u_lerr, t_tc, t_wrap, t_lerr;
   logic       c_up   = 1'b1;
   logic       c_load = 1'b0;
   logic [3:0] c_d    = 4'd0;

   int passed = 0;
   int total  = 0;

   int dec_q[4]  = '{1, 0, 9, 8};
   int dec_w[4]  = '{0, 0, 1, 0};
   int dec_tc[4] = '{0, 1, 0, 0};
   int flip_q[4] = '{6, 5, 6, 5};
   logic flip_up[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   always #5 clk = ~clk;

   tff_updown_counter #(.WIDTH(4), .MODULUS(16)) u_hex (
      .CLK(clk), .RST(rst), .EN(h_en), .UP(h_up), .LOAD(h_load), .D(h_d),
      .Q(h_q), .Qbar(h_qb), .TC(h_tc), .WRAP(h_wrap), .LOAD_ERR(h_lerr));

   tff_updown_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
      .CLK(clk), .RST(rst), .EN(d_en), .UP(d_up), .LOAD(d_load), .D(d_d),
      .Q(d_q), .Qbar(d_qb), .TC(d_tc), .WRAP(d_wrap), .LOAD_ERR(d_lerr));

   tff_updown_counter #(.WIDTH(4), .MODULUS(10)) u_units (
      .CLK(clk), .RST(rst), .EN(u_en), .UP(c_up), .LOAD(c_load), .D(c_d),
      .Q(u_q), .Qbar(u_qb), .TC(u_tc), .WRAP(u_wrap), .LOAD_ERR(u_lerr));

   tff_updown_counter #(.WIDTH(4), .MODULUS(10)) u_tens (
      .CLK(clk), .RST(rst), .EN(u_tc), .UP(c_up), .LOAD(c_load), .D(c_d),
      .Q(t_q), .Qbar(t_qb), .TC(t_tc), .WRAP(t_wrap), .LOAD_ERR(t_lerr));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tw;
      rst = 1'b1;
      h_en = 0; h_up = 1; h_load = 0; h_d = 0;
      d_en = 0; d_up = 1; d_load = 0; d_d = 0;
      u_en = 0;
      #12;
      chk("reset_q", 32'(h_q), 32'd0);
      chk("reset_qbar", 32'(h_qb), 32'hF);
      chk("reset_wrap", 32'(h_wrap), 32'd0);
      chk("reset_lerr", 32'(h_lerr), 32'd0);

      // count to 7, then reset between edges
      rst = 1'b0; h_en = 1; h_up = 1;
      for (int i = 0; i < 7; i++) step();
      chk("pre_reset_q", 32'(h_q), 32'd7);
      rst = 1'b1;
      #1;
      chk("async_reset_q", 32'(h_q), 32'd0);
      chk("async_reset_qbar", 32'(h_qb), 32'hF);
      chk("async_reset_wrap", 32'(h_wrap), 32'd0);
      #2;
      rst = 1'b0;

      // hex up wrap: 17 edges from 0
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("hex_up_q", 32'(h_q), 32'(i % 16));
         chk("hex_up_qbar", 32'(h_qb), 32'(~(i % 16) & 15));
         chk("hex_up_wrap", 32'(h_wrap), (i == 16) ? 32'd1 : 32'd0);
         chk("hex_up_tc", 32'(h_tc), ((i % 16) == 15) ? 32'd1 : 32'd0);
      end
      h_en = 0;

      // hex load priority: Q=3, LOAD+EN with D=12 -> 12
      h_load = 1; h_d = 4'd3;
      step();
      chk("hex_load3", 32'(h_q), 32'd3);
      h_en = 1; h_up = 1; h_d = 4'd12;
      #1;
      chk("hex_tc_masked_by_load", 32'(h_tc), 32'd0);
      step();
      chk("hex_load12_q", 32'(h_q), 32'd12);
      chk("hex_load12_lerr", 32'(h_lerr), 32'd0);
      chk("hex_load12_wrap", 32'(h_wrap), 32'd0);

      // direction flip from 5
      h_en = 0; h_d = 4'd5;
      step();
      chk("hex_load5", 32'(h_q), 32'd5);
      h_load = 0; h_en = 1;
      for (int i = 0; i < 4; i++) begin
         h_up = flip_up[i];
         step();
         chk("flip_q", 32'(h_q), 32'(flip_q[i]));
         chk("flip_wrap", 32'(h_wrap), 32'd0);
      end

      // hex down wrap 0 -> 15
      h_en = 0; h_load = 1; h_d = 4'd0;
      step();
      h_load = 0; h_en = 1; h_up = 0;
      #1;
      chk("hex_down_tc", 32'(h_tc), 32'd1);
      step();
      chk("hex_down_wrap_q", 32'(h_q), 32'd15);
      chk("hex_down_wrap_pulse", 32'(h_wrap), 32'd1);
      h_en = 0;
      step();
      chk("hex_hold_q", 32'(h_q), 32'd15);
      chk("hex_wrap_clears", 32'(h_wrap), 32'd0);

      // decade down from 2
      d_load = 1; d_d = 4'd2;
      step();
      chk("dec_load2", 32'(d_q), 32'd2);
      d_load = 0; d_en = 1; d_up = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("dec_down_q", 32'(d_q), 32'(dec_q[i]));
         chk("dec_down_wrap", 32'(d_wrap), 32'(dec_w[i]));
         chk("dec_down_tc", 32'(d_tc), 32'(dec_tc[i]));
      end

      // decade rejected load
      d_en = 0; d_load = 1; d_d = 4'd3;
      step();
      chk("dec_load3", 32'(d_q), 32'd3);
      d_en = 1; d_up = 1; d_d = 4'd12;
      step();
      chk("dec_badload_q", 32'(d_q), 32'd3);
      chk("dec_badload_lerr", 32'(d_lerr), 32'd1);
      d_load = 0; d_en = 0;
      step();
      chk("dec_lerr_clears", 32'(d_lerr), 32'd0);
      chk("dec_hold_q", 32'(d_q), 32'd3);

      // cascade 00..99..00
      tw = 0;
      chk("casc_start", 32'({t_q, u_q}), 32'h00);
      u_en = 1;
      for (int i = 1; i <= 100; i++) begin
         step();
         chk("casc_units", 32'(u_q), 32'(i % 10));
         chk("casc_tens", 32'(t_q), 32'((i % 100) / 10));
         if (t_wrap) tw++;
      end
      u_en = 0;
      chk("casc_tens_wrap_count", 32'(tw), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
